// File: rtl/pattern_detector_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// default sizes, the pat_len width helper and the configuration record.
package pattern_detector_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;

    // Widest pattern any instance may be built with; the config record is
    // sized for it so one typedef serves every instance.
    localparam int PAT_W_MAX = 32;
    localparam int LEN_W_MAX = 6;

    // Width needed to hold a length value 0..pat_w inclusive.
    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    typedef struct packed {
        logic [PAT_W_MAX-1:0] pattern;
        logic [LEN_W_MAX-1:0] len;
        logic                 overlap;
    } cfg_t;

endpackage

// File: rtl/patdet_match_cmp.sv
// Combinational masked comparator: compares the low len bits of the
// next-state history with the programmed pattern and checks that enough
// bits have been collected since the last restart of the fill count.
module patdet_match_cmp
    import pattern_detector_pkg::*;
#(
    parameter int CMP_W = PAT_W_MAX,
    parameter int LEN_W = 4
) (
    input  logic [CMP_W-1:0] hist_next,
    input  logic [CMP_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] fill,
    output logic             match
);

    logic [CMP_W-1:0] mask;
    logic [CMP_W-1:0] diff;
    logic [LEN_W:0]   fill_inc;

    // Build the length mask, then compare only the masked bits.
    always_comb begin
        mask = '0;
        for (int i = 0; i < CMP_W; i++) begin
            mask[i] = (i < int'(len));
        end
        diff     = (hist_next ^ cfg_pat) & mask;
        fill_inc = {1'b0, fill} + 1'b1;
        match    = (len != '0) && (fill_inc >= {1'b0, len}) && (diff == '0);
    end

endmodule

// File: rtl/pattern_detector_param.sv
// Parametrised serial bit-pattern detector with programmable pattern and
// length, overlapping / non-overlapping detection and a registered
// one-cycle match pulse. Optional feature macro: PATDET_COUNT_EN adds the
// saturating match counter and cnt_clr; without it match_count reads 0.
module pattern_detector_param
    import pattern_detector_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = calc_len_w(PAT_W),
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    if (PAT_W < 2 || PAT_W > PAT_W_MAX || LEN_W > LEN_W_MAX) begin : g_bad_size
        $error("pattern_detector_param: PAT_W out of supported range");
    end

    cfg_t             cfg_q, cfg_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             out_q, out_d;

    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] fill_inc;
    logic             cmp_match;
    logic             accept;
    logic             match;

    // The history MSB is shifted out before it could ever be compared.
    logic unused_hist_msb;
    assign unused_hist_msb = hist_q[PAT_W-1];

    assign accept    = valid & ~cfg_load;
    assign hist_next = {hist_q[PAT_W-2:0], in};
    assign match     = accept & cmp_match;

    // Clamp the programmed length to the physical history depth.
    always_comb begin
        eff_len = cfg_q.len[LEN_W-1:0];
        if (cfg_q.len > LEN_W_MAX'(PAT_W)) begin
            eff_len = LEN_W'(PAT_W);
        end
        fill_inc = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    end

    patdet_match_cmp #(
        .CMP_W (PAT_W_MAX),
        .LEN_W (LEN_W)
    ) u_cmp (
        .hist_next (PAT_W_MAX'(hist_next)),
        .cfg_pat   (cfg_q.pattern),
        .len       (eff_len),
        .fill      (fill_q),
        .match     (cmp_match)
    );

    // Next-state for config, history, fill count and match pulse;
    // cfg_load takes priority over (and drops) a concurrent input bit.
    always_comb begin
        cfg_d  = cfg_q;
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        if (cfg_load) begin
            cfg_d.pattern = PAT_W_MAX'(pattern);
            cfg_d.len     = LEN_W_MAX'(pat_len);
            cfg_d.overlap = overlap;
            hist_d        = '0;
            fill_d        = '0;
        end else if (valid) begin
            hist_d = hist_next;
            fill_d = fill_inc;
            if (match) begin
                out_d = 1'b1;
                if (!cfg_q.overlap) begin
                    fill_d = '0;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q  <= '0;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

`ifdef PATDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear first, then count the match; hold at all-ones.
    always_comb begin
        cnt_d = cnt_clr ? '0 : cnt_q;
        if (match && (cnt_d != {CNT_W{1'b1}})) begin
            cnt_d = cnt_d + 1'b1;
        end
    end

    // Match counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed bench for pattern_detector_param: one PAT_W=8/CNT_W=8 instance
// for the detection scenarios and one CNT_W=2 instance for saturation.
module tb_pattern_detector_param;

`ifdef PATDET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       in0 = 0, valid0 = 0, cfg_load0 = 0, overlap0 = 0, cnt_clr0 = 0;
    logic [7:0] pattern0 = '0;
    logic [3:0] pat_len0 = '0;
    logic       out0;
    logic [7:0] cnt0;

    logic       in1 = 0, valid1 = 0, cfg_load1 = 0, overlap1 = 0, cnt_clr1 = 0;
    logic [7:0] pattern1 = '0;
    logic [3:0] pat_len1 = '0;
    logic       out1;
    logic [1:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pattern_detector_param #(.PAT_W(8), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in(in0), .valid(valid0), .cfg_load(cfg_load0),
        .pattern(pattern0), .pat_len(pat_len0), .overlap(overlap0),
        .cnt_clr(cnt_clr0), .out(out0), .match_count(cnt0)
    );

    pattern_detector_param #(.PAT_W(8), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in(in1), .valid(valid1), .cfg_load(cfg_load1),
        .pattern(pattern1), .pat_len(pat_len1), .overlap(overlap1),
        .cnt_clr(cnt_clr1), .out(out1), .match_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock on dut0: drive at negedge, sample 1 time unit after posedge.
    task automatic drive0(input logic b, input logic v, input logic clr);
        @(negedge clk);
        in0 = b; valid0 = v; cnt_clr0 = clr;
        @(posedge clk);
        #1;
        valid0 = 1'b0; cnt_clr0 = 1'b0;
    endtask

    task automatic drive1(input logic b, input logic v, input logic clr);
        @(negedge clk);
        in1 = b; valid1 = v; cnt_clr1 = clr;
        @(posedge clk);
        #1;
        valid1 = 1'b0; cnt_clr1 = 1'b0;
    endtask

    task automatic load0(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        @(negedge clk);
        cfg_load0 = 1'b1; pattern0 = pat; pat_len0 = len; overlap0 = ovl;
        @(posedge clk);
        #1;
        cfg_load0 = 1'b0;
    endtask

    // Send n bits MSB-first, checking out after each against exp (MSB-first).
    task automatic send_seq0(input string tag, input logic [15:0] bits,
                             input int n, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            drive0(bits[i], 1'b1, 1'b0);
            check($sformatf("%s_b%0d", tag, n - i), {31'd0, out0}, {31'd0, exp[i]});
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0", {31'd0, out0}, 32'd0);
        check("rst_cnt0", {24'd0, cnt0}, 32'd0);
        check("rst_cnt1", {30'd0, cnt1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-overlap: one match after bit 5.
        load0(8'b10010, 4'd5, 1'b0);
        send_seq0("novl", 16'b10010010, 8, 16'b00001000);
        check("novl_cnt", {24'd0, cnt0}, CNT_EN ? 32'd1 : 32'd0);

        // Overlap: matches after bits 5 and 8.
        drive0(1'b0, 1'b0, 1'b1);
        check("clr_cnt", {24'd0, cnt0}, 32'd0);
        load0(8'b10010, 4'd5, 1'b1);
        send_seq0("ovl", 16'b10010010, 8, 16'b00001001);
        check("ovl_cnt", {24'd0, cnt0}, CNT_EN ? 32'd2 : 32'd0);

        // Valid gaps between accepted bits.
        load0(8'b10010, 4'd5, 1'b0);
        begin
            logic [4:0] gb;
            logic [4:0] ge;
            gb = 5'b10010;
            ge = 5'b00001;
            for (int i = 4; i >= 0; i--) begin
                drive0(gb[i], 1'b1, 1'b0);
                check($sformatf("gap_b%0d", 5 - i), {31'd0, out0}, {31'd0, ge[i]});
                for (int k = 0; k < 3; k++) begin
                    drive0(1'b1, 1'b0, 1'b0);
                    check($sformatf("gap_idle%0d_%0d", 5 - i, k), {31'd0, out0}, 32'd0);
                end
            end
        end

        // Reset mid-pattern discards history and config.
        load0(8'b10010, 4'd5, 1'b0);
        send_seq0("pre_rst", 16'b1001, 4, 16'b0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out", {31'd0, out0}, 32'd0);
        check("midrst_cnt", {24'd0, cnt0}, 32'd0);
        rst = 1'b0;
        send_seq0("norecfg", 16'b10010, 5, 16'b00000);
        load0(8'b10010, 4'd5, 1'b0);
        send_seq0("post_rst", 16'b010010, 6, 16'b000001);
        check("post_rst_cnt", {24'd0, cnt0}, CNT_EN ? 32'd1 : 32'd0);

        // Length 0 disables; changing inputs without cfg_load does nothing.
        load0(8'h00, 4'd0, 1'b1);
        pat_len0 = 4'd2;
        send_seq0("len0", 16'h0000, 8, 16'h0000);

        // Length above PAT_W clamps to 8.
        load0(8'hA5, 4'd12, 1'b0);
        send_seq0("len12", 16'b10100101, 8, 16'b00000001);

        // cfg_load with valid drops the bit and clears out.
        @(negedge clk);
        cfg_load0 = 1'b1; pattern0 = 8'h03; pat_len0 = 4'd2; overlap0 = 1'b1;
        in0 = 1'b1; valid0 = 1'b1;
        @(posedge clk);
        #1;
        cfg_load0 = 1'b0; valid0 = 1'b0;
        check("load_drop_out", {31'd0, out0}, 32'd0);
        send_seq0("load_drop", 16'b11, 2, 16'b01);

        // Saturating 2-bit counter on dut1.
        @(negedge clk);
        cfg_load1 = 1'b1; pattern1 = 8'h03; pat_len1 = 4'd2; overlap1 = 1'b1;
        @(posedge clk);
        #1;
        cfg_load1 = 1'b0;
        begin
            logic [5:0] se;
            se = 6'b011111;
            for (int i = 5; i >= 0; i--) begin
                drive1(1'b1, 1'b1, 1'b0);
                check($sformatf("sat_out_b%0d", 6 - i), {31'd0, out1}, {31'd0, se[i]});
            end
        end
        check("sat_cnt", {30'd0, cnt1}, CNT_EN ? 32'd3 : 32'd0);
        drive1(1'b1, 1'b1, 1'b1);
        check("clr_match_out", {31'd0, out1}, 32'd1);
        check("clr_match_cnt", {30'd0, cnt1}, CNT_EN ? 32'd1 : 32'd0);
        drive1(1'b0, 1'b0, 1'b0);
        check("sat_idle_out", {31'd0, out1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
